// File: rtl/piano_pkg.sv
// Shared constants and types for the piano tone generator: the note
// half-period table, the octave clamp and the player state encoding.
package piano_pkg;

  localparam int NOTE_COUNT = 8;
  localparam int HALF_W     = 17;

  // Highest octave shift actually applied; larger requests are clamped here.
  localparam logic [1:0] OCT_MAX = 2'd2;

  // Half-period in 50 MHz clock cycles, index 0 = Do4 .. index 7 = Do5.
  localparam logic [NOTE_COUNT-1:0][HALF_W-1:0] HALF_PERIOD = {
    17'd47778,  // Do5
    17'd50619,  // Si
    17'd56818,  // La
    17'd63776,  // Sol
    17'd71586,  // Fa
    17'd75843,  // Mi
    17'd85133,  // Re
    17'd95556   // Do4
  };

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE,
    STOPPING
  } state_e;

  // Octave codes 2 and 3 both mean +2 octaves, so they are folded together
  // before latching; switching between them is therefore not a note change.
  function automatic logic [1:0] clampOctave(input logic [1:0] oct);
    return (oct > OCT_MAX) ? OCT_MAX : oct;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter plus speaker toggle flop. The counter runs from 0 up
// to the terminal count, then wraps and flips the speaker, giving a square
// wave of period 2*(tc+1) cycles.
module tone_divider #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [CNT_W-1:0] tc,
  input  logic             force_low,
  output logic             speaker,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             speaker_q, speaker_d;

  // Raw terminal-count flag; the controller only acts on it while running.
  assign wrap    = (count_q == tc);
  assign speaker = speaker_q;

  // Next counter/speaker value: force_low beats restart, restart beats a
  // toggle, and a stalled divider parks its counter at zero.
  always_comb begin
    count_d   = count_q;
    speaker_d = speaker_q;
    if (force_low) begin
      count_d   = '0;
      speaker_d = 1'b0;
    end else if (restart) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == tc) begin
        count_d   = '0;
        speaker_d = ~speaker_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = '0;
    end
  end

  // Counter and speaker registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      speaker_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      speaker_q <= speaker_d;
    end
  end

endmodule

// File: rtl/piano_tone_gen.sv
// Eight-note square-wave player with octave shift, a release tail after
// key-up and a stop sequence that always leaves the speaker low.
module piano_tone_gen
  import piano_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int CNT_W          = 19,
  parameter int NUM_KEYS       = 8,
  parameter int REL_W          = 23,
  parameter int RELEASE_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          octave,
  output logic                speaker,
  output logic                busy,
  output logic [2:0]          note_idx
);

  // The half-period table is only valid for eight keys on a 50 MHz-class
  // clock, so any other key count is refused at elaboration.
  if (NUM_KEYS != NOTE_COUNT || CLK_HZ <= 0) begin : gen_bad_params
    $error("piano_tone_gen: NUM_KEYS must be 8 and CLK_HZ positive");
  end

  localparam logic [REL_W-1:0] REL_LOAD =
    (RELEASE_CYCLES == 0) ? '0 : REL_W'(RELEASE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       note_q, note_d;
  logic [1:0]       oct_q, oct_d;
  logic [REL_W-1:0] relTimer_q, relTimer_d;
  logic             busy_q;

  logic [2:0]       keyNote;
  logic             pressed;
  logic [1:0]       octEff;
  logic             changed;
  logic [CNT_W-1:0] tc;
  logic             run, restart, forceLow;
  logic             wrap;

  // Priority encoder: scanning from the top down lets the lowest set key
  // overwrite the result last, so the lowest key wins.
  always_comb begin
    keyNote = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) keyNote = 3'(i);
    end
  end

  assign pressed = |keys;
  assign octEff  = clampOctave(octave);
  assign changed = (keyNote != note_q) || (octEff != oct_q);

  // The divider always plays the latched note, never the live key input.
  assign tc = CNT_W'(HALF_PERIOD[note_q] >> oct_q) - CNT_W'(1);

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .restart  (restart),
    .tc       (tc),
    .force_low(forceLow),
    .speaker  (speaker),
    .wrap     (wrap)
  );

  // Player FSM: chooses the next state and tells the divider whether to
  // run, restart on a new note, or force the speaker low. A relatch always
  // restarts the counter instead of toggling, so a note change adds no edge.
  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    oct_d      = oct_q;
    relTimer_d = relTimer_q;
    run        = 1'b0;
    restart    = 1'b0;
    forceLow   = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      forceLow = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          forceLow = 1'b1;
          if (pressed) begin
            note_d  = keyNote;
            oct_d   = octEff;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (pressed) begin
            if (changed) begin
              note_d  = keyNote;
              oct_d   = octEff;
              restart = 1'b1;
            end else begin
              run = 1'b1;
            end
          end else begin
            run = 1'b1;
            if (RELEASE_CYCLES == 0) begin
              state_d = STOPPING;
            end else begin
              state_d    = RELEASE;
              relTimer_d = REL_LOAD;
            end
          end
        end
        RELEASE: begin
          if (pressed) begin
            if (changed) begin
              note_d  = keyNote;
              oct_d   = octEff;
              restart = 1'b1;
            end else begin
              run = 1'b1;
            end
            state_d = PLAY;
          end else begin
            run = 1'b1;
            if (relTimer_q == '0) begin
              state_d = STOPPING;
            end else begin
              relTimer_d = relTimer_q - REL_W'(1);
            end
          end
        end
        STOPPING: begin
          if (!speaker) begin
            forceLow = 1'b1;
            state_d  = IDLE;
          end else begin
            run = 1'b1;
            if (wrap) state_d = IDLE;
          end
        end
        default: begin
          state_d  = IDLE;
          forceLow = 1'b1;
        end
      endcase
    end
  end

  // State, latched note/octave, release timer and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      note_q     <= '0;
      oct_q      <= '0;
      relTimer_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      oct_q      <= oct_d;
      relTimer_q <= relTimer_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign busy     = busy_q;
  assign note_idx = note_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Bench for piano_tone_gen: directed scenarios followed by random key/octave
// /enable traffic, every cycle compared against a countdown-based model.
module tb_piano_tone_gen;

  localparam int REL_CYC   = 1000;
  localparam int MISS_STOP = 40;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_REL  = 2;
  localparam int M_STOP = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] keys;
  logic [1:0] octave;
  logic       speaker;
  logic       busy;
  logic [2:0] note_idx;

  int vectorCount = 0;
  int missCount   = 0;
  int cycleCount  = 0;

  int HALF [8] = '{95556, 85133, 75843, 71586, 63776, 56818, 50619, 47778};

  int   mState, mNote, mOct, mRemain, mRelLeft;
  logic mSpk;

  piano_tone_gen #(
    .RELEASE_CYCLES(REL_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .keys    (keys),
    .octave  (octave),
    .speaker (speaker),
    .busy    (busy),
    .note_idx(note_idx)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reportSummary();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectorCount++;
    if (got != exp) begin
      missCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleCount, got, exp);
      if (missCount >= MISS_STOP) reportSummary();
    end
  endtask

  function automatic int halfOf(input int n, input int o);
    return HALF[n] >> o;
  endfunction

  function automatic int lowestKey(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mState   = M_IDLE;
    mSpk     = 1'b0;
    mNote    = 0;
    mOct     = 0;
    mRemain  = 0;
    mRelLeft = 0;
  endtask

  // One running cycle of the tone: count down to the next edge.
  task automatic advanceTone();
    if (mRemain <= 1) begin
      mSpk    = ~mSpk;
      mRemain = halfOf(mNote, mOct);
    end else begin
      mRemain--;
    end
  endtask

  task automatic relatch(input int n, input int o);
    mNote   = n;
    mOct    = o;
    mRemain = halfOf(n, o);
  endtask

  task automatic modelStep();
    int  enc, oe;
    bit  pressed, differs;
    if (!rst_n) begin
      modelReset();
      return;
    end
    pressed = (keys != 8'h00);
    enc     = lowestKey(keys);
    oe      = (octave > 2'd2) ? 2 : int'(octave);
    differs = (enc != mNote) || (oe != mOct);
    if (!en) begin
      mState = M_IDLE;
      mSpk   = 1'b0;
    end else begin
      case (mState)
        M_IDLE: if (pressed) begin
          relatch(enc, oe);
          mState = M_PLAY;
        end
        M_PLAY: begin
          if (pressed) begin
            if (differs) relatch(enc, oe);
            else advanceTone();
          end else begin
            advanceTone();
            mState   = M_REL;
            mRelLeft = REL_CYC;
          end
        end
        M_REL: begin
          if (pressed) begin
            if (differs) relatch(enc, oe);
            else advanceTone();
            mState = M_PLAY;
          end else begin
            advanceTone();
            if (mRelLeft == 1) mState = M_STOP;
            else mRelLeft--;
          end
        end
        default: begin
          if (!mSpk) begin
            mState = M_IDLE;
          end else begin
            advanceTone();
            if (!mSpk) mState = M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("speaker", int'(speaker), int'(mSpk));
    checkOutput("busy", int'(busy), (mState != M_IDLE) ? 1 : 0);
    checkOutput("note_idx", int'(note_idx), mNote);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep();
      #1;
      cycleCount++;
      compareAll();
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] k, input logic [1:0] o, input int n);
    en     = e;
    keys   = k;
    octave = o;
    runCycles(n);
  endtask

  // Pull reset between clock edges and confirm outputs clear at once.
  task automatic resetMidTone();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    runCycles(3);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rk;
    logic [1:0] ro;
    logic       re;
    int         pick;

    rst_n  = 1'b0;
    en     = 1'b0;
    keys   = 8'h00;
    octave = 2'd0;
    modelReset();
    #12;
    compareAll();
    rst_n = 1'b1;

    // Do and La together: Do wins; octave moves 1 -> 2 -> 3 (3 clamps to 2).
    applyStimulus(1'b1, 8'b0010_0001, 2'd1, 2000);
    applyStimulus(1'b1, 8'b0010_0001, 2'd2, 1000);
    applyStimulus(1'b1, 8'b0010_0001, 2'd3, 1000);
    // Do5 long enough for a high edge, then switch to Si with no extra edge.
    applyStimulus(1'b1, 8'b1000_0000, 2'd2, 12200);
    applyStimulus(1'b1, 8'b0100_0000, 2'd2, 300);
    // Enable drop while speaker is high.
    applyStimulus(1'b0, 8'b0100_0000, 2'd2, 300);
    // La until high, release, stop on the falling edge; a press during
    // STOPPING is held off until IDLE, then retriggers.
    applyStimulus(1'b1, 8'b0010_0000, 2'd2, 14500);
    applyStimulus(1'b1, 8'b0000_0000, 2'd2, 1100);
    applyStimulus(1'b1, 8'b0100_0000, 2'd2, 14000);
    // La while speaker low, release: STOPPING leaves next cycle.
    applyStimulus(1'b1, 8'b0010_0000, 2'd2, 3000);
    applyStimulus(1'b1, 8'b0000_0000, 2'd2, 1100);
    // Re-press with Mi inside the release tail.
    applyStimulus(1'b1, 8'b0010_0000, 2'd2, 2000);
    applyStimulus(1'b1, 8'b0000_0000, 2'd2, 400);
    applyStimulus(1'b1, 8'b0000_0100, 2'd2, 2000);
    // Asynchronous reset mid-tone with the key still held.
    resetMidTone();
    applyStimulus(1'b1, 8'b0000_0100, 2'd2, 1000);

    // Random traffic with octave +2 favoured so edges actually occur.
    while (cycleCount < 72000) begin
      pick = $urandom_range(0, 9);
      if (pick < 3)      rk = 8'h00;
      else if (pick < 7) rk = 8'(1 << $urandom_range(0, 7));
      else               rk = 8'($urandom);
      ro = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      re = ($urandom_range(0, 19) != 0);
      applyStimulus(re, rk, ro, $urandom_range(20, 2500));
    end

    reportSummary();
  end

endmodule
